// File: rtl/ir_queue_store.sv
// ---------------------------------------------------------------------------
// ir_queue_store
//   Circular backing store behind the ir_queue head register. Holds ENTRIES
//   instruction words in arrival order. Read and write pointers wrap modulo
//   ENTRIES. Occupancy is tracked by the parent, which guarantees that it
//   never writes while the store is full or reads while it is empty.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (pointers to 0)
//   i_flush    : synchronous pointer clear (redirect)
//   i_wr_en    : write i_wr_data at the write pointer and advance it
//   i_wr_data  : word to store
//   i_rd_en    : advance the read pointer (the word at o_rd_data is consumed)
//   o_rd_data  : word at the read pointer (oldest stored word)
// ---------------------------------------------------------------------------
module ir_queue_store #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [0:WIDTH-1] i_wr_data,
    input  logic             i_rd_en,
    output logic [0:WIDTH-1] o_rd_data
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [PW-1:0] LAST = PW'(ENTRIES - 1);

    logic [0:WIDTH-1] r_mem [0:ENTRIES-1];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_ptr_next;
    logic [PW-1:0]    w_rd_ptr_next;

    // Pointers wrap at ENTRIES, which need not be a power of two.
    function automatic logic [PW-1:0] f_advance(input logic [PW-1:0] ptr);
        if (ptr == LAST) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    assign w_wr_ptr_next = i_wr_en ? f_advance(r_wr_ptr) : r_wr_ptr;
    assign w_rd_ptr_next = i_rd_en ? f_advance(r_rd_ptr) : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // Storage array carries no reset so it maps onto RAM primitives; stale
    // entries are never observed because occupancy lives in the parent.
    always_ff @(posedge clk) begin
        if (i_wr_en && !rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // The parent's head register is the registered stage of this read.
    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/ir_queue.sv
// ---------------------------------------------------------------------------
// ir_queue
//   DEPTH-entry instruction prefetch queue feeding the instruction decoder.
//   The head word is held in the registered output q; the remaining DEPTH-1
//   words live in a circular store (ir_queue_store). Fetch logic pushes words,
//   the decoder pops the head when it accepts an instruction.
//   invalidate clears the top INV_BITS of the presented word so that no
//   LIP/SP-class request can be decoded while an illegal-instruction
//   interrupt is being served. flush discards everything on a redirect.
//
// Ports (bit 0 is the MSB of every word)
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   d          : word to push
//   push       : push d this cycle
//   full       : count == DEPTH
//   pop        : decoder consumed the head word
//   q          : registered head word, invalidate mask applied
//   q_valid    : q holds a valid word (count >= 1)
//   empty      : count == 0
//   count      : words held, including q
//   invalidate : mask the head word after this edge
//   flush      : discard all contents
//   overflow   : sticky, push while full without a pop
// ---------------------------------------------------------------------------
module ir_queue #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int INV_BITS = 2,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] d,
    input  logic             push,
    output logic             full,
    input  logic             pop,
    output logic [0:WIDTH-1] q,
    output logic             q_valid,
    output logic             empty,
    output logic [CW-1:0]    count,
    input  logic             invalidate,
    input  logic             flush,
    output logic             overflow
);

    // INV_BITS ones in the most significant positions (q[0:INV_BITS-1]).
    localparam logic [0:WIDTH-1] INV_MASK = ~({WIDTH{1'b1}} >> INV_BITS);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);

    logic [0:WIDTH-1] r_q;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_q_valid;
    logic             w_full;
    logic             w_store_empty;
    logic             w_pop_e;
    logic             w_push_e;
    logic             w_bypass;
    logic             w_store_wr;
    logic             w_store_rd;
    logic [0:WIDTH-1] w_store_data;
    logic [0:WIDTH-1] w_q_load;
    logic [0:WIDTH-1] w_q_next;
    logic [CW-1:0]    w_count_next;
    logic             w_overflow_set;

    // Flow-control flags are functions of the count register alone.
    assign w_q_valid     = (r_count != '0);
    assign w_full        = (r_count == DEPTH_C);
    // The store holds everything except the head word.
    assign w_store_empty = (r_count <= ONE_C);

    assign w_pop_e  = pop & w_q_valid;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push_e = push & (~w_full | w_pop_e);

    // d goes straight into q when the head slot is (or becomes) free and the
    // store has nothing older to offer; otherwise it queues behind.
    assign w_bypass   = w_push_e & (~w_q_valid | (w_pop_e & w_store_empty));
    assign w_store_wr = w_push_e & ~w_bypass;
    assign w_store_rd = w_pop_e & ~w_store_empty;

    assign w_overflow_set = push & w_full & ~w_pop_e;

    assign w_count_next = r_count + CW'(w_push_e) - CW'(w_pop_e);

    always_comb begin
        w_q_load = r_q;
        if (w_store_rd) begin
            w_q_load = w_store_data;
        end else if (w_bypass) begin
            w_q_load = d;
        end
        // Invalidate applies to whatever q holds after the edge, including a
        // word loaded this very cycle; no effect once the queue drains.
        w_q_next = w_q_load;
        if (invalidate && (w_count_next != '0)) begin
            w_q_next = w_q_load & ~INV_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_q        <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_count <= w_count_next;
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    ir_queue_store #(
        .WIDTH   (WIDTH),
        .ENTRIES (DEPTH - 1)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_wr_en   (w_store_wr),
        .i_wr_data (d),
        .i_rd_en   (w_store_rd),
        .o_rd_data (w_store_data)
    );

    assign q        = r_q;
    assign q_valid  = w_q_valid;
    assign empty    = ~w_q_valid;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ir_queue.sv
// ---------------------------------------------------------------------------
// tb_ir_queue
//   Self-checking bench for ir_queue (WIDTH=16, DEPTH=4, INV_BITS=2).
//   A queue-level reference model predicts every output; a compare process
//   checks the DUT against it on each falling edge. Directed scenarios with
//   hand-computed literals pin the model, then a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ir_queue;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int INV_BITS = 2;
    localparam int CW       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [0:WIDTH-1] d = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             invalidate = 1'b0;
    logic             flush = 1'b0;
    logic             full;
    logic [0:WIDTH-1] q;
    logic             q_valid;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;

    ir_queue #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .INV_BITS (INV_BITS),
        .CW       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .push       (push),
        .full       (full),
        .pop        (pop),
        .q          (q),
        .q_valid    (q_valid),
        .empty      (empty),
        .count      (count),
        .invalidate (invalidate),
        .flush      (flush),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit model_live = 1'b0;

    // ---------------- reference model ----------------
    logic [15:0] m_words[$];     // all words held, oldest first (head = [0])
    logic [15:0] m_q = 16'h0;    // value presented on q
    bit          m_ovf = 1'b0;
    logic [15:0] m_mask;

    initial m_mask = 16'hFFFF << (16 - INV_BITS);

    always @(posedge clk) begin
        int  sz;
        bit  pe, ue, head_changed;
        sz = m_words.size();
        if (rst || flush) begin
            m_words.delete();
            m_q   = 16'h0;
            m_ovf = 1'b0;
        end else begin
            pe = pop && (sz > 0);
            ue = push && ((sz < DEPTH) || pe);
            if (push && (sz == DEPTH) && !pe) m_ovf = 1'b1;
            head_changed = pe || (sz == 0 && ue);
            if (pe) void'(m_words.pop_front());
            if (ue) m_words.push_back(d);
            if (head_changed && m_words.size() > 0) m_q = m_words[0];
            if (invalidate && m_words.size() > 0) m_q = m_q & ~m_mask;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("count",    int'(count),    m_words.size());
            chk("q_valid",  int'(q_valid),  int'(m_words.size() > 0));
            chk("empty",    int'(empty),    int'(m_words.size() == 0));
            chk("full",     int'(full),     int'(m_words.size() == DEPTH));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (m_words.size() > 0) chk("q", int'(q), int'(m_q));
        end
    end

    // One clock: apply inputs at the falling edge, let the rising edge take
    // them, return at the next falling edge with outputs settled.
    task automatic step(input logic pu, input logic [15:0] dd, input logic po,
                        input logic inv, input logic fl);
        push = pu; d = dd; pop = po; invalidate = inv; flush = fl; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        $display("txn push=%0b d=%04h pop=%0b inv=%0b flush=%0b -> q=%04h qv=%0b cnt=%0d ovf=%0b",
                 pu, dd, po, inv, fl, q, q_valid, count, overflow);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_live = 1'b1;

        // 1. reset state
        step(0, 16'h0, 0, 0, 0);
        chk("rst_q", int'(q), 16'h0000);
        chk("rst_qv", int'(q_valid), 0);
        chk("rst_cnt", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ovf", int'(overflow), 0);

        // 2. fill to full, then overflow
        step(1, 16'hC123, 0, 0, 0);
        chk("bypass_q", int'(q), 16'hC123);
        chk("bypass_cnt", int'(count), 1);
        step(1, 16'h1111, 0, 0, 0);
        step(1, 16'h2222, 0, 0, 0);
        step(1, 16'h3333, 0, 0, 0);
        chk("fill_cnt", int'(count), 4);
        chk("fill_full", int'(full), 1);
        step(1, 16'h4444, 0, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_cnt", int'(count), 4);

        // 3. pop+push at full, drain across wrap
        step(1, 16'h5555, 1, 0, 0);
        chk("pp_full_q", int'(q), 16'h1111);
        chk("pp_full_cnt", int'(count), 4);
        step(0, 16'h0, 1, 0, 0);
        chk("drain_q1", int'(q), 16'h2222);
        step(0, 16'h0, 1, 0, 0);
        chk("drain_q2", int'(q), 16'h3333);
        step(0, 16'h0, 1, 0, 0);
        chk("drain_q3", int'(q), 16'h5555);

        // 4. invalidate on held word, then on a word loaded the same cycle
        step(0, 16'h0, 1, 0, 0);
        step(1, 16'hC123, 0, 0, 0);
        step(0, 16'h0, 0, 1, 0);
        chk("inv_q", int'(q), 16'h0123);
        chk("inv_cnt", int'(count), 1);
        step(1, 16'hFFFF, 0, 0, 0);
        step(0, 16'h0, 1, 1, 0);
        chk("inv_load_q", int'(q), 16'h3FFF);

        // 5. flush with push at count 3 (overflow still set from step 2)
        step(1, 16'h0001, 0, 0, 0);
        step(1, 16'h0002, 0, 0, 0);
        chk("pre_flush_cnt", int'(count), 3);
        step(1, 16'hAAAA, 0, 0, 1);
        chk("flush_cnt", int'(count), 0);
        chk("flush_qv", int'(q_valid), 0);
        chk("flush_q", int'(q), 16'h0000);
        chk("flush_ovf", int'(overflow), 0);
        step(1, 16'hAAAA, 0, 0, 0);
        chk("post_flush_q", int'(q), 16'hAAAA);

        // 6. pop+push at count 1, then pop on empty
        step(1, 16'h7777, 1, 0, 0);
        chk("pp_one_q", int'(q), 16'h7777);
        chk("pp_one_cnt", int'(count), 1);
        step(0, 16'h0, 1, 0, 0);
        step(0, 16'h0, 1, 0, 0);
        chk("pop_empty_cnt", int'(count), 0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic rr, ff;
            rr = ($urandom_range(0, 199) == 0);
            ff = ($urandom_range(0, 59) == 0);
            push = ($urandom_range(0, 99) < 60);
            pop = ($urandom_range(0, 99) < 45);
            invalidate = ($urandom_range(0, 99) < 10);
            flush = ff;
            d = 16'($urandom);
            rst = rr;
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0; push = 1'b0; pop = 1'b0; invalidate = 1'b0; flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single instruction register: a DEPTH-entry instruction prefetch queue feeding the instruction decoder.
- Memory-fetch logic pushes instruction words; the decoder sees the head word on registered output q and pops it when the instruction is accepted.
- Keeps the legacy "invalidate" function, which forces the top INV_BITS of the presented word to zero so the decoder cannot issue LIP/SP-class requests while an illegal-instruction interrupt is being served.
- Adds flush (branch/interrupt redirect), full/empty flow control and a sticky overflow flag.

Parameters:
- WIDTH, 16: instruction word width; bit 0 is the MSB, ports are [0:WIDTH-1].
- DEPTH, 4: total capacity in words, including the head word held in q. Must be ≥ 2.
- INV_BITS, 2: number of MSBs (q[0:INV_BITS-1]) cleared by invalidate. Range 1..WIDTH.
- CW, $clog2(DEPTH+1): width of count.

Ports:
- clk, in, 1: system clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- d, in, WIDTH: word to push.
- push, in, 1: push d this cycle.
- full, out, 1: count == DEPTH.
- pop, in, 1: the decoder consumed the head word.
- q, out, WIDTH: registered head word, with the invalidate mask applied.
- q_valid, out, 1: q holds a valid word (count ≥ 1).
- empty, out, 1: count == 0. Equal to !q_valid.
- count, out, CW: number of words held.
- invalidate, in, 1: mask the head word.
- flush, in, 1: discard all contents.
- overflow, out, 1: sticky flag; set when push arrives while full and pop is not asserted.

Behaviour:
- Reset (rst high at an edge):
  - q = 0, q_valid = 0, count = 0, overflow = 0, both pointers = 0.
  - rst overrides every other input.
- Structure:
  - Output register q.
  - Circular backing store of DEPTH-1 words, with read/write pointers that wrap modulo DEPTH-1.
  - count covers q plus the backing store.
- Effective operations per edge:
  - pop_e = pop & q_valid; a pop on empty is ignored.
  - push_e = push & (!full | pop_e); a push while full is accepted if a pop happens in the same cycle.
  - A push while full without pop is dropped and sets overflow.
- Head-register load rules:
  - q_valid=0 and push_e: d goes straight into q (bypass). Latency push→q_valid is 1 cycle.
  - pop_e and store non-empty: q ← store[rd_ptr]; rd_ptr advances.
  - pop_e, store empty, push_e: q ← d (bypass).
  - pop_e, store empty, no push: q_valid ← 0; q holds its old value (don't care).
  - Otherwise q holds.
- Store write: when push_e and d is not bypassed into q, store[wr_ptr] ← d and wr_ptr advances.
- count update: count += push_e − pop_e. Simultaneous push and pop leaves count unchanged, at every fill level including full and count == 1.
- FIFO order is strictly preserved, including across pointer wrap-around.
- invalidate:
  - Sampled at the edge.
  - Clears q[0:INV_BITS-1] of the value q holds after that edge, including a word loaded into q in the same cycle (invalidate beats load).
  - Remaining bits of q and words in the store are unaffected. A word popped later from the store arrives unmasked unless invalidate is asserted again.
  - Ignored when the resulting q_valid is 0.
- flush:
  - count, q_valid and the pointers go to 0; q ← 0.
  - A push in the same cycle is discarded.
  - overflow is cleared.
  - Priority is rst > flush > push/pop > invalidate.
- Combinational outputs: full, empty and q_valid are derived from count only; no combinational path from inputs to outputs.

Decomposition:
- No shared package needed. Parameters are local; a constant INV_MASK (INV_BITS ones followed by zeros) is computed inside the module.
- One natural sub-module, ir_queue_store: the circular store of DEPTH-1 words with wr/rd pointers and wrap logic. The head register, count, invalidate and flush stay in ir_queue.

Test Plan (defaults WIDTH=16, DEPTH=4, INV_BITS=2):
1. rst for 1 cycle, then idle → q=0x0000, q_valid=0, count=0, empty=1, overflow=0.
2. Push 0xC123 in one cycle → next cycle q=0xC123, q_valid=1, count=1.
   Push 0x1111, 0x2222, 0x3333 → count=4, full=1.
   Push 0x4444 without pop → dropped, overflow=1, count=4.
3. From that full state, pop + push 0x5555 together → q=0x1111, count=4.
   Three further pops → q=0x2222, 0x3333, 0x5555, in order across pointer wrap.
4. With q=0xC123 valid, assert invalidate → q=0x0123, count unchanged.
   Then pop with next word 0xFFFF and invalidate in the same cycle → q=0x3FFF.
5. With count=3, assert flush together with push 0xAAAA → count=0, q_valid=0, q=0, overflow=0.
   Next cycle push 0xAAAA → q=0xAAAA one cycle later.
6. count=1, pop + push 0x7777 in the same cycle (store empty) → q=0x7777, q_valid=1, count=1.
   Pop on empty → ignored, count stays 0.
